// File: rtl/minmax_sequencer.sv
// minmax_sequencer: frame-level scheduler that time-multiplexes one external
// max/min comparator to track the running maximum and minimum of a frame of
// `len` unsigned samples, then reports both with a one-cycle done pulse.
//
// Handshake: a sample transfers on a rising clk edge only when in_valid and
// in_ready are both high in that cycle; in_ready is a pure decode of the
// current state (LOAD/WAIT) and never depends combinationally on in_valid.
module minmax_sequencer #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    output logic               cmp_m,
    input  logic [WIDTH-1:0]   cmp_y,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   max_out,
    output logic [WIDTH-1:0]   min_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_CMP_MAX = 3'd3,
        S_CMP_MIN = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [COUNT_W-1:0] len_reg;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0]   max_reg;
    logic [WIDTH-1:0]   min_reg;
    logic [WIDTH-1:0]   smp_reg;
    logic               last_cmp;
    logic               load_last;

    // cnt counts samples folded into the running results; no wrap since len < 2^COUNT_W
    assign cnt_inc   = cnt + COUNT_W'(1);
    assign last_cmp  = (cnt_inc == len_reg);
    assign load_last = (len_reg == COUNT_W'(1));

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    next_state = load_last ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    next_state = S_CMP_MAX;
                end
            end
            S_CMP_MAX: next_state = S_CMP_MIN;
            S_CMP_MIN: next_state = last_cmp ? S_DONE : S_WAIT;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Output decode: handshake, busy flag and comparator operand steering
    always_comb begin
        in_ready = 1'b0;
        busy     = (state != S_IDLE);
        cmp_a    = '0;
        cmp_b    = '0;
        cmp_m    = 1'b0;
        case (state)
            S_LOAD, S_WAIT: in_ready = 1'b1;
            S_CMP_MAX: begin
                cmp_a = max_reg;
                cmp_b = smp_reg;
                cmp_m = 1'b0;
            end
            S_CMP_MIN: begin
                cmp_a = min_reg;
                cmp_b = smp_reg;
                cmp_m = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: frame length, running max/min, sample holding register and results
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg <= '0;
            cnt     <= '0;
            max_reg <= '0;
            min_reg <= '0;
            smp_reg <= '0;
            max_out <= '0;
            min_out <= '0;
            done    <= 1'b0;
        end else begin
            // done is a flop that is high exactly while the FSM sits in DONE
            done <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_reg <= len;
                        cnt     <= '0;
                        if (len == '0) begin
                            max_out <= '0;
                            min_out <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        max_reg <= in_data;
                        min_reg <= in_data;
                        cnt     <= COUNT_W'(1);
                        if (load_last) begin
                            max_out <= in_data;
                            min_out <= in_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        smp_reg <= in_data;
                    end
                end
                S_CMP_MAX: begin
                    max_reg <= cmp_y;
                end
                S_CMP_MIN: begin
                    min_reg <= cmp_y;
                    cnt     <= cnt_inc;
                    if (last_cmp) begin
                        // max_reg already holds the final maximum from CMP_MAX
                        max_out <= max_reg;
                        min_out <= cmp_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_sequencer.sv
// Testbench for minmax_sequencer: drives frames with random data and gaps,
// pushes the expected {max,min} of each issued frame into a queue, and a
// negedge monitor with an abstract frame model checks handshake, comparator
// operands, done timing and held results every cycle.
module tb_minmax_sequencer;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [COUNT_W-1:0] len = '0;
  logic               in_valid = 1'b0;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_ready;
  logic [WIDTH-1:0]   cmp_a;
  logic [WIDTH-1:0]   cmp_b;
  logic               cmp_m;
  logic [WIDTH-1:0]   cmp_y;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   max_out;
  logic [WIDTH-1:0]   min_out;

  int checks = 0;
  int errors = 0;

  logic [2*WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]   frame_q[$];

  // external comparator beside the block
  assign cmp_y = cmp_m ? ((cmp_a < cmp_b) ? cmp_a : cmp_b)
                       : ((cmp_a > cmp_b) ? cmp_a : cmp_b);

  minmax_sequencer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_m    (cmp_m),
    .cmp_y    (cmp_y),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .min_out  (min_out)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor with abstract frame model ----------------
  int               cyc = 0;
  bit               m_active = 1'b0;
  bit               m_open = 1'b0;
  int               m_phase = 0;
  int               m_idx = 0;
  int               m_len = 0;
  int               m_due = -1;
  logic [WIDTH-1:0] m_max = '0;
  logic [WIDTH-1:0] m_min = '0;
  logic [WIDTH-1:0] m_smp = '0;
  logic [WIDTH-1:0] held_max = '0;
  logic [WIDTH-1:0] held_min = '0;

  always @(negedge clk) begin : monitor
    bit               exp_ready;
    bit               exp_done;
    bit               was_active;
    logic [2*WIDTH-1:0] e;
    exp_ready = m_open && (m_phase == 0);
    exp_done  = (m_due == cyc);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(exp_done));
    if (m_phase == 1) begin
      chk("cmp_a_max", 32'(cmp_a), 32'(m_max));
      chk("cmp_b_max", 32'(cmp_b), 32'(m_smp));
      chk("cmp_m_max", 32'(cmp_m), 32'd0);
    end else if (m_phase == 2) begin
      chk("cmp_a_min", 32'(cmp_a), 32'(m_min));
      chk("cmp_b_min", 32'(cmp_b), 32'(m_smp));
      chk("cmp_m_min", 32'(cmp_m), 32'd1);
    end else begin
      chk("cmp_a_idle", 32'(cmp_a), 32'd0);
      chk("cmp_b_idle", 32'(cmp_b), 32'd0);
      chk("cmp_m_idle", 32'(cmp_m), 32'd0);
    end
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        held_max = e[2*WIDTH-1:WIDTH];
        held_min = e[WIDTH-1:0];
      end
      chk("max_out_done", 32'(max_out), 32'(held_max));
      chk("min_out_done", 32'(min_out), 32'(held_min));
    end else begin
      chk("max_out_hold", 32'(max_out), 32'(held_max));
      chk("min_out_hold", 32'(min_out), 32'(held_min));
    end

    // model update for the coming clock edge
    if (m_phase == 1) begin
      if (m_smp > m_max) m_max = m_smp;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (m_smp < m_min) m_min = m_smp;
      m_phase = 0;
    end
    was_active = m_active;
    if (exp_done) m_active = 1'b0;
    if (start && !was_active) begin
      m_active = 1'b1;
      m_len    = int'(len);
      m_idx    = 0;
      if (len == '0) m_due = cyc + 1;
      else m_open = 1'b1;
    end else if (in_valid && exp_ready) begin
      if (m_idx == 0) begin
        m_max = in_data;
        m_min = in_data;
      end else begin
        m_smp   = in_data;
        m_phase = 1;
      end
      m_idx++;
      if (m_idx == m_len) begin
        m_open = 1'b0;
        m_due  = cyc + ((m_len == 1) ? 1 : 3);
      end
    end
    if (rst) begin
      m_active = 1'b0;
      m_open   = 1'b0;
      m_phase  = 0;
      m_idx    = 0;
      m_due    = -1;
      held_max = '0;
      held_min = '0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int l);
    start = 1'b1;
    len   = COUNT_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom_range(0, 255));
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] s, input int gap, input bit poke_start);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      if (poke_start && i == 0) begin
        start = 1'b1;
        len   = 8'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = s;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept of %0d", s);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end
    @(posedge clk); #1;
  endtask

  task automatic push_expected();
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    mx = '0;
    mn = '0;
    if (frame_q.size() > 0) begin
      mx = frame_q[0];
      mn = frame_q[0];
    end
    foreach (frame_q[i]) begin
      if (frame_q[i] > mx) mx = frame_q[i];
      if (frame_q[i] < mn) mn = frame_q[i];
    end
    exp_q.push_back({mx, mn});
  endtask

  task automatic run_frame(input int gap_max);
    push_expected();
    start_frame(frame_q.size());
    foreach (frame_q[i]) begin
      send_sample(frame_q[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, 1'b0);
    end
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int l;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // basic frame
    frame_q = '{8'd33, 8'd122, 8'd68};
    run_frame(0);

    // equal and boundary values
    frame_q = '{8'd5, 8'd5, 8'd255, 8'd0};
    run_frame(0);
    frame_q = '{8'd68, 8'd68};
    run_frame(0);

    // degenerate lengths
    frame_q = '{8'd167};
    run_frame(0);
    frame_q.delete();
    run_frame(0);

    // stream gaps with a start pulse while busy
    frame_q = '{8'd112, 8'd103, 8'd141};
    push_expected();
    start_frame(3);
    send_sample(8'd112, 0, 1'b0);
    send_sample(8'd103, 4, 1'b1);
    send_sample(8'd141, 4, 1'b0);
    wait_done();

    // reset mid-frame: aborted frame produces no result
    start_frame(5);
    send_sample(8'd200, 0, 1'b0);
    send_sample(8'd17, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame_q = '{8'd132, 8'd141};
    run_frame(0);

    // result hold with no start
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // random frames
    for (int f = 0; f < 10; f++) begin
      l = int'($urandom_range(1, 8));
      frame_q.delete();
      for (int i = 0; i < l; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) frame_q.push_back(frame_q[i-1]);
        else frame_q.push_back(8'($urandom_range(0, 255)));
      end
      run_frame(3);
    end

    // maximum frame length
    frame_q.delete();
    for (int i = 0; i < 255; i++) frame_q.push_back(8'($urandom_range(1, 254)));
    run_frame(0);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/minmax_sequencer.md
Name: minmax_sequencer

Overview:
- Frame-level scheduler for the shared 8-bit max/min mode comparator (combinational: a, b, m → y; m=0 gives max(a,b), m=1 gives min(a,b)).
- Accepts a frame of `len` samples over a valid/ready stream. Time-multiplexes the single comparator to track the running maximum and minimum.
- Reports both results with a one-cycle done pulse.
- The comparator is instantiated beside this block in the top level and driven through the cmp_* ports.

Parameters:
- WIDTH, 8, sample / comparator data width
- COUNT_W, 8, width of frame-length field; max frame length 2^COUNT_W-1

Ports:
- clk  input  1  system clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- len  input  COUNT_W  frame length, captured on accepted start
- in_valid  input  1  sample present on in_data
- in_data  input  WIDTH  sample value, unsigned
- in_ready  output  1  block can accept a sample this cycle
- cmp_a  output  WIDTH  comparator operand a
- cmp_b  output  WIDTH  comparator operand b
- cmp_m  output  1  comparator mode: 0=max, 1=min
- cmp_y  input  WIDTH  comparator result, combinational from cmp_a/b/m
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, results valid
- max_out  output  WIDTH  frame maximum, held until next done
- min_out  output  WIDTH  frame minimum, held until next done

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, all counters and registers cleared, in_ready=0, busy=0, done=0, max_out=0, min_out=0, cmp_a=0, cmp_b=0, cmp_m=0.
- Reset asserted mid-frame: abort immediately, no done pulse; partial results discarded; max_out/min_out cleared.
- States: IDLE, LOAD, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0: capture len, clear cnt, go LOAD.
  - start=1 and len==0: load max_out=min_out=0, go DONE.
- LOAD:
  - in_ready=1.
  - On in_valid: max_reg=min_reg=in_data, cnt=1.
  - If len==1, load max_out/min_out from the sample and go DONE; else go WAIT.
- WAIT:
  - in_ready=1.
  - On in_valid: smp_reg=in_data, go CMP_MAX.
  - in_valid=0: stay; gaps of any length are legal.
- CMP_MAX:
  - in_ready=0; cmp_a=max_reg, cmp_b=smp_reg, cmp_m=0.
  - max_reg<=cmp_y; go CMP_MIN.
- CMP_MIN:
  - in_ready=0; cmp_a=min_reg, cmp_b=smp_reg, cmp_m=1.
  - min_reg<=cmp_y; cnt<=cnt+1.
  - If cnt+1==len: load max_out<=max_reg, min_out<=cmp_y, go DONE; else go WAIT.
- DONE:
  - done=1 for exactly this cycle; busy=1; go IDLE.
- Comparator port defaults: outside CMP_MAX/CMP_MIN, cmp_a=cmp_b=0 and cmp_m=0.
- Handshake: a sample transfers only when in_valid && in_ready in the same cycle. in_ready is a pure state decode with no combinational path from in_valid.
- Throughput: after the first sample, one sample per 3 cycles at most.
- Latency:
  - Sample accepted in WAIT at cycle t: CMP_MAX at t+1, CMP_MIN at t+2.
  - If that sample is the last, done=1 in cycle t+3.
  - len==1: done at t+1 after the LOAD accept.
  - len==0: done the cycle after start.
- start while busy is ignored; len is not recaptured mid-frame.
- Equal operands: the comparator result equals both operands; no special handling in this block.
- Counter: cnt is COUNT_W bits. len ≤ 2^COUNT_W-1 guarantees no wrap.
- max_out/min_out change only on entry to DONE (or reset) and are stable between frames.
- done and max_out/min_out are registered outputs.

Test Plan:
- Basic frame: start, len=3, samples 33,122,68 with in_valid held high.
  - Required: in_ready high only in LOAD/WAIT.
  - Required: cmp_m=0 then 1 for each of samples 2 and 3.
  - Required: done pulse 3 cycles after the last accept, max_out=122, min_out=33.
- Equal and boundary values: len=4, samples 5,5,255,0 → max_out=255, min_out=0. Second frame len=2, samples 68,68 → max_out=68, min_out=68.
- Degenerate lengths:
  - len=1, sample 167 → done one cycle after accept, max_out=min_out=167.
  - len=0 → done the cycle after start, max_out=min_out=0, in_ready never high.
- Stream gaps and start-while-busy: len=3, samples 112,103,141 with 4-cycle in_valid gaps, start pulsed mid-frame with len=9.
  - Required: start ignored, frame still ends after 3 samples with max_out=141, min_out=103.
  - Required: in_valid during CMP states does not transfer.
- Reset mid-frame: len=5, rst asserted for 1 cycle after 2 samples.
  - Required next cycle: IDLE, busy=0, max_out=min_out=0, no done pulse.
  - Then a new frame of len=2 (132,141) completes with max_out=141, min_out=132.
- Result hold: after a frame completes, vary in_data/in_valid with no start for 20 cycles. Required: max_out/min_out unchanged, done stays 0, cmp_a=cmp_b=0.
